// File: rtl/mac_accumulator_16_if.sv
// Product-in / result-out handshake bundle for mac_accumulator_16.
// slave is the accumulator's view; master is the view of the surrounding logic.
`timescale 1ns/1ps
interface mac_accumulator_16_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 9
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_ovf;
    logic              acc_forced;

    modport slave (
        input  prod_valid, prod_data, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_count, acc_ovf, acc_forced
    );

    modport master (
        output prod_valid, prod_data, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf, acc_forced
    );
endinterface

// File: rtl/mac_accumulator_16.sv
// Accumulates a stream of multiplier products into one sum per group (closed by last or MAX_TERMS).
// Define MAC_ACC_SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.
`timescale 1ns/1ps
module mac_accumulator_16 #(
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 40,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_accumulator_16_if.slave    bus
);
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_TERMS);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             forced_q, forced_d;
    logic             ready_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum;
    logic [CNT_W:0]   cnt_inc;
    logic             prod_fire;
    logic             hit_max;
    logic             carry;

    assign prod_ext  = ACC_W'(bus.prod_data);
    assign sum       = {1'b0, acc_q} + {1'b0, prod_ext};
    assign carry     = sum[ACC_W];
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit_max   = (cnt_inc == MAX_CNT);
    assign prod_fire = bus.prod_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        forced_d = forced_q;
        case (state_q)
            ST_ACCUM: begin
                if (prod_fire) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_q == '0) begin
                        acc_d = prod_ext;
                        ovf_d = 1'b0;
                    end else begin
`ifdef MAC_ACC_SATURATE_EN
                        // Once clamped, the sum stays pinned for the rest of the group.
                        acc_d = (carry || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        ovf_d = ovf_q | carry;
                    end
                    if (bus.prod_last || hit_max) begin
                        state_d  = ST_HOLD;
                        forced_d = hit_max & ~bus.prod_last;
                    end
                end
            end
            default: begin
                if (bus.acc_ready) begin
                    state_d  = ST_ACCUM;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    forced_d = 1'b0;
                end
            end
        endcase
    end

    // prod_ready is registered so it reads 0 throughout the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            forced_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            forced_q <= forced_d;
            ready_q  <= (state_d == ST_ACCUM);
        end
    end

    assign bus.prod_ready = ready_q;
    assign bus.acc_valid  = (state_q == ST_HOLD);
    assign bus.acc_data   = acc_q;
    assign bus.acc_count  = cnt_q;
    assign bus.acc_ovf    = ovf_q;
    assign bus.acc_forced = forced_q;
endmodule

// File: tb/tb_mac_accumulator_16.sv
// Bench for mac_accumulator_16: two instances (ACC_W=33/MAX_TERMS=4 and ACC_W=40/MAX_TERMS=1),
// expected results queued as stimulus is driven and checked when each result handshake happens.
`timescale 1ns/1ps
module tb_mac_accumulator_16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_accumulator_16_if #(.PROD_W(32), .ACC_W(33), .CNT_W(9)) bus_a ();
    mac_accumulator_16_if #(.PROD_W(32), .ACC_W(40), .CNT_W(9)) bus_b ();

    mac_accumulator_16 #(.PROD_W(32), .ACC_W(33), .MAX_TERMS(4), .CNT_W(9)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mac_accumulator_16 #(.PROD_W(32), .ACC_W(40), .MAX_TERMS(1), .CNT_W(9)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic [39:0] data;
        logic [8:0]  cnt;
        logic        ovf;
        logic        forced;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int total = 0;
    int bad   = 0;

    // Scoreboard: one comparison per completed result handshake.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus_a.acc_valid === 1'b1 && bus_a.acc_ready === 1'b1) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_result: got data=%h count=%0d, required no result", bus_a.acc_data, bus_a.acc_count);
            end else begin
                ea = q_a.pop_front();
                if (40'(bus_a.acc_data) !== ea.data || bus_a.acc_count !== ea.cnt ||
                    bus_a.acc_ovf !== ea.ovf || bus_a.acc_forced !== ea.forced) begin
                    bad++;
                    $display("FAIL a_result: got data=%h count=%0d ovf=%b forced=%b, required data=%h count=%0d ovf=%b forced=%b",
                             bus_a.acc_data, bus_a.acc_count, bus_a.acc_ovf, bus_a.acc_forced,
                             ea.data, ea.cnt, ea.ovf, ea.forced);
                end else begin
                    $display("a result data=%h count=%0d ovf=%b forced=%b ok", bus_a.acc_data, bus_a.acc_count, bus_a.acc_ovf, bus_a.acc_forced);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && bus_b.acc_valid === 1'b1 && bus_b.acc_ready === 1'b1) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_result: got data=%h count=%0d, required no result", bus_b.acc_data, bus_b.acc_count);
            end else begin
                eb = q_b.pop_front();
                if (bus_b.acc_data !== eb.data || bus_b.acc_count !== eb.cnt ||
                    bus_b.acc_ovf !== eb.ovf || bus_b.acc_forced !== eb.forced) begin
                    bad++;
                    $display("FAIL b_result: got data=%h count=%0d ovf=%b forced=%b, required data=%h count=%0d ovf=%b forced=%b",
                             bus_b.acc_data, bus_b.acc_count, bus_b.acc_ovf, bus_b.acc_forced,
                             eb.data, eb.cnt, eb.ovf, eb.forced);
                end else begin
                    $display("b result data=%h count=%0d ovf=%b forced=%b ok", bus_b.acc_data, bus_b.acc_count, bus_b.acc_ovf, bus_b.acc_forced);
                end
            end
        end
    end

    // Tasks start and end at 1 ns after a rising edge.
    task automatic send_a(input logic [31:0] p, input logic last);
        int n = 0;
        bus_a.prod_valid = 1'b1;
        bus_a.prod_data  = p;
        bus_a.prod_last  = last;
        @(negedge clk);
        while (bus_a.prod_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL a_send_timeout: got prod_ready=%b, required 1 within 50 cycles", bus_a.prod_ready);
        end
        @(posedge clk);
        #1;
        bus_a.prod_valid = 1'b0;
        $display("a product %h last=%b", p, last);
    endtask

    task automatic send_b(input logic [31:0] p, input logic last);
        int n = 0;
        bus_b.prod_valid = 1'b1;
        bus_b.prod_data  = p;
        bus_b.prod_last  = last;
        @(negedge clk);
        while (bus_b.prod_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL b_send_timeout: got prod_ready=%b, required 1 within 50 cycles", bus_b.prod_ready);
        end
        @(posedge clk);
        #1;
        bus_b.prod_valid = 1'b0;
        $display("b product %h last=%b", p, last);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus_a.prod_ready !== 1'b0 || bus_a.acc_valid !== 1'b0 || bus_a.acc_data !== 33'd0 ||
            bus_a.acc_count !== 9'd0 || bus_a.acc_ovf !== 1'b0 || bus_a.acc_forced !== 1'b0 ||
            bus_b.prod_ready !== 1'b0 || bus_b.acc_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got a.ready=%b a.valid=%b a.data=%h a.count=%0d a.ovf=%b a.forced=%b b.ready=%b b.valid=%b, required all 0",
                     bus_a.prod_ready, bus_a.acc_valid, bus_a.acc_data, bus_a.acc_count,
                     bus_a.acc_ovf, bus_a.acc_forced, bus_b.prod_ready, bus_b.acc_valid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus_a.prod_ready !== 1'b1 || bus_b.prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got a=%b b=%b, required 1 1", bus_a.prod_ready, bus_b.prod_ready);
        end
        $display("reset check done");
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bus_a.acc_ready = 1'b1;
        q_a.push_back('{data: 40'h00FFFE001B, cnt: 9'd3, ovf: 1'b0, forced: 1'b0});
        send_a(32'd6, 1'b0);
        send_a(32'd20, 1'b0);
        send_a(32'hFFFE0001, 1'b1);
        @(negedge clk);
        total++;
        if (bus_a.acc_valid !== 1'b1 || bus_a.prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold_cycle: got valid=%b ready=%b, required 1 0", bus_a.acc_valid, bus_a.prod_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus_a.acc_valid !== 1'b0 || bus_a.prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_back_to_accum: got valid=%b ready=%b, required 0 1", bus_a.acc_valid, bus_a.prod_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bus_a.acc_ready = 1'b0;
        q_a.push_back('{data: 40'h00FFFE001B, cnt: 9'd3, ovf: 1'b0, forced: 1'b0});
        send_a(32'd6, 1'b0);
        send_a(32'd20, 1'b0);
        send_a(32'hFFFE0001, 1'b1);
        // A product offered while holding must be ignored.
        bus_a.prod_valid = 1'b1;
        bus_a.prod_data  = 32'hDEAD_BEEF;
        bus_a.prod_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus_a.acc_valid !== 1'b1 || bus_a.prod_ready !== 1'b0 ||
                bus_a.acc_data !== 33'h0FFFE001B || bus_a.acc_count !== 9'd3) begin
                bad++;
                $display("FAIL backpressure_stable[%0d]: got valid=%b ready=%b data=%h count=%0d, required 1 0 0fffe001b 3",
                         i, bus_a.acc_valid, bus_a.prod_ready, bus_a.acc_data, bus_a.acc_count);
            end
        end
        @(posedge clk);
        #1;
        bus_a.prod_valid = 1'b0;
        bus_a.acc_ready  = 1'b1;
        q_a.push_back('{data: 40'd5, cnt: 9'd1, ovf: 1'b0, forced: 1'b0});
        send_a(32'd5, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_forced();
        q_a.push_back('{data: 40'd4, cnt: 9'd4, ovf: 1'b0, forced: 1'b1});
        q_a.push_back('{data: 40'd2, cnt: 9'd2, ovf: 1'b0, forced: 1'b0});
        for (int i = 0; i < 5; i++) send_a(32'd1, 1'b0);
        @(negedge clk);
        total++;
        if (bus_a.acc_data !== 33'd1 || bus_a.acc_count !== 9'd1 || bus_a.acc_valid !== 1'b0) begin
            bad++;
            $display("FAIL forced_second_group_start: got data=%h count=%0d valid=%b, required 1 1 0",
                     bus_a.acc_data, bus_a.acc_count, bus_a.acc_valid);
        end
        @(posedge clk);
        #1;
        send_a(32'd1, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [39:0] exp_data;
`ifdef MAC_ACC_SATURATE_EN
        exp_data = 40'h01FFFFFFFF;
`else
        exp_data = 40'h0000000000;
`endif
        q_a.push_back('{data: exp_data, cnt: 9'd3, ovf: 1'b1, forced: 1'b0});
        send_a(32'hFFFFFFFF, 1'b0);
        send_a(32'hFFFFFFFF, 1'b0);
        send_a(32'd2, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        send_a(32'd11, 1'b0);
        send_a(32'd12, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus_a.acc_count !== 9'd0 || bus_a.acc_ovf !== 1'b0 || bus_a.acc_valid !== 1'b0 ||
            bus_a.prod_ready !== 1'b0 || bus_a.acc_data !== 33'd0) begin
            bad++;
            $display("FAIL reset_mid_cleared: got count=%0d ovf=%b valid=%b ready=%b data=%h, required 0 0 0 0 0",
                     bus_a.acc_count, bus_a.acc_ovf, bus_a.acc_valid, bus_a.prod_ready, bus_a.acc_data);
        end
        @(posedge clk);
        #1;
        q_a.push_back('{data: 40'd7, cnt: 9'd1, ovf: 1'b0, forced: 1'b0});
        send_a(32'd7, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_limit_one();
        bus_b.acc_ready = 1'b1;
        q_b.push_back('{data: 40'd9, cnt: 9'd1, ovf: 1'b0, forced: 1'b0});
        q_b.push_back('{data: 40'd3, cnt: 9'd1, ovf: 1'b0, forced: 1'b1});
        send_b(32'd9, 1'b1);
        send_b(32'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus_a.prod_valid = 1'b0;
        bus_a.prod_data  = '0;
        bus_a.prod_last  = 1'b0;
        bus_a.acc_ready  = 1'b1;
        bus_b.prod_valid = 1'b0;
        bus_b.prod_data  = '0;
        bus_b.prod_last  = 1'b0;
        bus_b.acc_ready  = 1'b1;

        test_reset();
        test_basic();
        test_backpressure();
        test_forced();
        test_overflow();
        test_reset_mid();
        test_limit_one();

        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL results_outstanding: got a=%0d b=%0d pending, required 0 0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000 ns, required finish");
        $fatal(1);
    end
endmodule
